// File: rtl/vga_rect_overlay_if.sv
// Configuration bus for vga_rect_overlay: per-rectangle fields packed as rect i at [i*W +: W].
// The controller (master) drives the fields and load strobe; the overlay reports pending.
interface vga_rect_overlay_if #(
  parameter int N_RECT = 4,
  parameter int CW     = 11,
  parameter int RGB_W  = 12
);
  logic                    cfg_load;
  logic [N_RECT-1:0]       cfg_en;
  logic [N_RECT-1:0]       cfg_mode;
  logic [N_RECT*CW-1:0]    cfg_xmin;
  logic [N_RECT*CW-1:0]    cfg_xmax;
  logic [N_RECT*CW-1:0]    cfg_ymin;
  logic [N_RECT*CW-1:0]    cfg_ymax;
  logic [N_RECT*RGB_W-1:0] cfg_color;
  logic                    cfg_pending;

  modport master (
    output cfg_load, cfg_en, cfg_mode, cfg_xmin, cfg_xmax, cfg_ymin, cfg_ymax, cfg_color,
    input  cfg_pending
  );

  modport slave (
    input  cfg_load, cfg_en, cfg_mode, cfg_xmin, cfg_xmax, cfg_ymin, cfg_ymax, cfg_color,
    output cfg_pending
  );
endinterface

// File: rtl/vga_rect_overlay.sv
// Multi-rectangle overlay stage: solid or sprite fills over the background, with
// double-buffered configuration swapped at vblank start and a fixed 2+ROM_LAT latency.
module vga_rect_overlay #(
  parameter int               N_RECT    = 4,
  parameter int               CW        = 11,
  parameter int               RGB_W     = 12,
  parameter int               ROM_LAT   = 1,
  parameter int               KEY_EN    = 1,
  parameter logic [RGB_W-1:0] KEY_COLOR = 'hF0F
) (
  input  logic                                     pclk,
  input  logic                                     rst,
  input  logic [CW-1:0]                            hcount_in,
  input  logic                                     hsync_in,
  input  logic                                     hblnk_in,
  input  logic [CW-1:0]                            vcount_in,
  input  logic                                     vsync_in,
  input  logic                                     vblnk_in,
  input  logic [RGB_W-1:0]                         rgb_in,
  vga_rect_overlay_if.slave                        cfg,
  output logic [CW-1:0]                            rom_addr_x,
  output logic [CW-1:0]                            rom_addr_y,
  output logic [((N_RECT > 1) ? $clog2(N_RECT) : 1)-1:0] rom_id,
  input  logic [RGB_W-1:0]                         rom_data,
  output logic                                     hsync_out,
  output logic                                     hblnk_out,
  output logic                                     vsync_out,
  output logic                                     vblnk_out,
  output logic [RGB_W-1:0]                         rgb_out
);
  localparam int IDW = (N_RECT > 1) ? $clog2(N_RECT) : 1;

  typedef struct packed {
    logic             hit;
    logic             mode;
    logic [RGB_W-1:0] color;
    logic [RGB_W-1:0] rgb;
    logic             hsync;
    logic             hblnk;
    logic             vsync;
    logic             vblnk;
  } pix_t;

  logic [N_RECT-1:0]       stg_en, stg_mode, act_en, act_mode;
  logic [N_RECT*CW-1:0]    stg_xmin, stg_xmax, stg_ymin, stg_ymax;
  logic [N_RECT*CW-1:0]    act_xmin, act_xmax, act_ymin, act_ymax;
  logic [N_RECT*RGB_W-1:0] stg_color, act_color;
  logic                    pending;
  logic                    vblnk_prev;
  logic                    vblnk_rise;

  assign vblnk_rise      = vblnk_in & ~vblnk_prev;
  assign cfg.cfg_pending = pending;

  // Swap precedes capture, so a load on the swap edge refills staging and keeps pending set.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      stg_en <= '0; stg_mode <= '0; stg_color <= '0;
      stg_xmin <= '0; stg_xmax <= '0; stg_ymin <= '0; stg_ymax <= '0;
      act_en <= '0; act_mode <= '0; act_color <= '0;
      act_xmin <= '0; act_xmax <= '0; act_ymin <= '0; act_ymax <= '0;
      pending    <= 1'b0;
      vblnk_prev <= 1'b0;
    end else begin
      vblnk_prev <= vblnk_in;
      if (vblnk_rise && pending) begin
        act_en <= stg_en; act_mode <= stg_mode; act_color <= stg_color;
        act_xmin <= stg_xmin; act_xmax <= stg_xmax;
        act_ymin <= stg_ymin; act_ymax <= stg_ymax;
        pending <= 1'b0;
      end
      if (cfg.cfg_load) begin
        stg_en <= cfg.cfg_en; stg_mode <= cfg.cfg_mode; stg_color <= cfg.cfg_color;
        stg_xmin <= cfg.cfg_xmin; stg_xmax <= cfg.cfg_xmax;
        stg_ymin <= cfg.cfg_ymin; stg_ymax <= cfg.cfg_ymax;
        pending <= 1'b1;
      end
    end
  end

  logic             win_hit, win_mode;
  logic [IDW-1:0]   win_idx;
  logic [RGB_W-1:0] win_color;
  logic [CW-1:0]    win_dx, win_dy;

  // Scanning from the top index down lets the lowest-numbered hit overwrite the others.
  always_comb begin
    win_hit   = 1'b0;
    win_mode  = 1'b0;
    win_idx   = '0;
    win_color = '0;
    win_dx    = '0;
    win_dy    = '0;
    for (int i = N_RECT - 1; i >= 0; i--) begin
      if (act_en[i] &&
          hcount_in >= act_xmin[i*CW +: CW] && hcount_in <= act_xmax[i*CW +: CW] &&
          vcount_in >= act_ymin[i*CW +: CW] && vcount_in <= act_ymax[i*CW +: CW]) begin
        win_hit   = 1'b1;
        win_mode  = act_mode[i];
        win_idx   = IDW'(i);
        win_color = act_color[i*RGB_W +: RGB_W];
        win_dx    = hcount_in - act_xmin[i*CW +: CW];
        win_dy    = vcount_in - act_ymin[i*CW +: CW];
      end
    end
  end

  pix_t s1;
  pix_t dl [ROM_LAT];
  pix_t tail;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      s1         <= '0;
      rom_addr_x <= '0;
      rom_addr_y <= '0;
      rom_id     <= '0;
    end else begin
      s1.hit   <= win_hit;
      s1.mode  <= win_mode;
      s1.color <= win_color;
      s1.rgb   <= rgb_in;
      s1.hsync <= hsync_in;
      s1.hblnk <= hblnk_in;
      s1.vsync <= vsync_in;
      s1.vblnk <= vblnk_in;
      if (win_hit && win_mode) begin
        rom_addr_x <= win_dx;
        rom_addr_y <= win_dy;
        rom_id     <= win_idx;
      end else begin
        rom_addr_x <= '0;
        rom_addr_y <= '0;
        rom_id     <= '0;
      end
    end
  end

  // Holds the S1 result until the ROM answers for the same pixel.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROM_LAT; i++) dl[i] <= '0;
    end else begin
      dl[0] <= s1;
      for (int i = 1; i < ROM_LAT; i++) dl[i] <= dl[i-1];
    end
  end

  assign tail = dl[ROM_LAT-1];

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      hsync_out <= 1'b0;
      hblnk_out <= 1'b0;
      vsync_out <= 1'b0;
      vblnk_out <= 1'b0;
      rgb_out   <= '0;
    end else begin
      hsync_out <= tail.hsync;
      hblnk_out <= tail.hblnk;
      vsync_out <= tail.vsync;
      vblnk_out <= tail.vblnk;
      if (tail.hblnk || tail.vblnk)
        rgb_out <= '0;
      else if (!tail.hit)
        rgb_out <= tail.rgb;
      else if (!tail.mode)
        rgb_out <= tail.color;
      else if ((KEY_EN != 0) && (rom_data == KEY_COLOR))
        rgb_out <= tail.rgb;
      else
        rgb_out <= rom_data;
    end
  end
endmodule
